// File: rtl/shift_reg_universal.sv
// Universal shift register (SISO/SIPO/PISO/PIPO) with a shift counter and a frame-complete pulse.
// Define SHIFT_REG_ROTATE_EN to enable rotate modes 100/101; otherwise those codes hold.
module shift_reg_universal #(
    parameter int unsigned WIDTH = 4,
    // Derived from WIDTH; do not override.
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic             data_in,
    input  logic [WIDTH-1:0] par_in,
    input  logic             set_all_ones,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic [CW-1:0]    bit_count,
    output logic             frame_done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;

    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] data_next;
    logic [CW-1:0]    count_next;
    logic             done_next;
    logic             shift_exec;

    // Next-state decode: preset beats mode operations; only shifts and rotates advance the count.
    always_comb begin
        data_next  = data_out;
        count_next = bit_count;
        done_next  = 1'b0;
        shift_exec = 1'b0;

        if (set_all_ones) begin
            data_next  = '1;
            count_next = '0;
        end else if (enable) begin
            case (mode)
                MODE_SHR: begin
                    data_next  = {data_in, data_out[WIDTH-1:1]};
                    shift_exec = 1'b1;
                end
                MODE_SHL: begin
                    data_next  = {data_out[WIDTH-2:0], data_in};
                    shift_exec = 1'b1;
                end
                MODE_LOAD: begin
                    data_next  = par_in;
                    count_next = '0;
                end
`ifdef SHIFT_REG_ROTATE_EN
                MODE_ROR: begin
                    data_next  = {data_out[0], data_out[WIDTH-1:1]};
                    shift_exec = 1'b1;
                end
                MODE_ROL: begin
                    data_next  = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
                    shift_exec = 1'b1;
                end
`endif
                default: begin
                    data_next = data_out;
                end
            endcase

            // Wrap at WIDTH-1 explicitly so non-power-of-two widths frame correctly.
            if (shift_exec) begin
                if (bit_count == COUNT_LAST) begin
                    count_next = '0;
                    done_next  = 1'b1;
                end else begin
                    count_next = bit_count + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            bit_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            data_out   <= data_next;
            bit_count  <= count_next;
            frame_done <= done_next;
        end
    end

    // Bit that leaves on the next shift: MSB for left-going modes, LSB otherwise.
    assign serial_out = (mode == MODE_SHL || mode == MODE_ROL) ? data_out[WIDTH-1] : data_out[0];

endmodule
